// File: rtl/detector_colision_if.sv
// rtl/detector_colision_if.sv - signal bundle between the game logic and the collision detector
// Purpose: groups the game-state, obstacle and hero inputs with the
//          collision/score outputs of detector_colision.
// Signals:
//   presente       3  current game state (master -> slave)
//   clk_obstaculos 1  slow obstacle clock (master -> slave)
//   display_obs    7  hero-side obstacle digit segments (master -> slave)
//   heroe          7  hero segment pattern (master -> slave)
//   choque         1  one-clk pulse per counted collision (slave -> master)
//   vidas          2  remaining lives (slave -> master)
//   puntos         8  BCD score {tens, units} (slave -> master)
//   invulnerable   1  hits currently ignored (slave -> master)
//   gano           1  sticky win flag (slave -> master)
//   perdio         1  sticky loss flag (slave -> master)
interface detector_colision_if;
  logic [2:0] presente;
  logic       clk_obstaculos;
  logic [6:0] display_obs;
  logic [6:0] heroe;
  logic       choque;
  logic [1:0] vidas;
  logic [7:0] puntos;
  logic       invulnerable;
  logic       gano;
  logic       perdio;

  modport master (
    output presente, clk_obstaculos, display_obs, heroe,
    input  choque, vidas, puntos, invulnerable, gano, perdio
  );

  modport slave (
    input  presente, clk_obstaculos, display_obs, heroe,
    output choque, vidas, puntos, invulnerable, gano, perdio
  );
endinterface

// File: rtl/detector_colision.sv
// rtl/detector_colision.sv - obstacle collision detector with lives and BCD score
// Purpose: once per clk_obstaculos period, checks the obstacle digit against
//          the hero pattern, charges lives on hits, scores passes in BCD and
//          raises sticky win/loss flags for the game state machine.
// Ports:
//   clk  1  system clock
//   rst  1  asynchronous reset, active-high
//   bus     detector_colision_if.slave (see interface file for signals)
module detector_colision #(
  parameter int         VIDAS     = 3,
  parameter int         INV_TICKS = 2,
  parameter logic [7:0] META      = 8'h20,
  parameter logic [2:0] OFF       = 3'd0,
  parameter logic [2:0] WLCM      = 3'd1,
  parameter logic [2:0] CH        = 3'd2,
  parameter logic [2:0] GAME      = 3'd3,
  parameter logic [2:0] WL        = 3'd4,
  parameter logic [2:0] PA        = 3'd5
) (
  input logic          clk,
  input logic          rst,
  detector_colision_if.slave bus
);

  typedef enum logic [1:0] {INIT, JUGANDO, INVULN, FIN} state_t;

  state_t     state_q, state_d;
  logic [1:0] vidas_q, vidas_d;
  logic [7:0] puntos_q, puntos_d;
  logic [1:0] cnt_q, cnt_d;
  logic       gano_q, gano_d;
  logic       perdio_q, perdio_d;
  logic       choque_q, choque_d;

  // [0],[1]: synchronizer; [2]: previous synchronized level for edge detect
  logic [2:0] sync_q;
  logic       tick;
  logic       eval_q;
  logic [6:0] obs_q, heroe_q;
  logic       hit, pass;
  logic [7:0] puntos_inc;

  assign tick = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 3'b000;
      eval_q  <= 1'b0;
      obs_q   <= 7'h00;
      heroe_q <= 7'h00;
    end else begin
      sync_q <= {sync_q[1:0], bus.clk_obstaculos};
      // Ticks outside GAME are dropped here rather than queued
      eval_q <= tick && (bus.presente == GAME);
      if (tick) begin
        obs_q   <= bus.display_obs;
        heroe_q <= bus.heroe;
      end
    end
  end

  assign hit  = eval_q && ((obs_q & heroe_q) != 7'h00);
  assign pass = eval_q && (obs_q != 7'h00) && !hit;

  always_comb begin
    puntos_inc = puntos_q;
    if (puntos_q[3:0] == 4'd9) puntos_inc = {puntos_q[7:4] + 4'd1, 4'd0};
    else                       puntos_inc = {puntos_q[7:4], puntos_q[3:0] + 4'd1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      vidas_q  <= 2'(VIDAS);
      puntos_q <= 8'h00;
      cnt_q    <= 2'd0;
      gano_q   <= 1'b0;
      perdio_q <= 1'b0;
      choque_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vidas_q  <= vidas_d;
      puntos_q <= puntos_d;
      cnt_q    <= cnt_d;
      gano_q   <= gano_d;
      perdio_q <= perdio_d;
      choque_q <= choque_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vidas_d  = vidas_q;
    puntos_d = puntos_q;
    cnt_d    = cnt_q;
    gano_d   = gano_q;
    perdio_d = perdio_q;
    choque_d = 1'b0;
    case (bus.presente)
      OFF, WLCM, CH: begin
        state_d  = INIT;
        vidas_d  = 2'(VIDAS);
        puntos_d = 8'h00;
        cnt_d    = 2'd0;
        gano_d   = 1'b0;
        perdio_d = 1'b0;
      end
      GAME: begin
        case (state_q)
          INIT: state_d = JUGANDO;
          JUGANDO: begin
            if (hit) begin
              vidas_d  = vidas_q - 2'd1;
              choque_d = 1'b1;
              if (vidas_q == 2'd1) begin
                perdio_d = 1'b1;
                state_d  = FIN;
              end else begin
                cnt_d   = 2'(INV_TICKS);
                state_d = INVULN;
              end
            end else if (pass) begin
              puntos_d = puntos_inc;
              if (puntos_inc == META) begin
                gano_d  = 1'b1;
                state_d = FIN;
              end
            end
          end
          INVULN: begin
            if (eval_q) begin
              cnt_d = cnt_q - 2'd1;
              if (cnt_q == 2'd1) state_d = JUGANDO;
              if (pass) begin
                puntos_d = puntos_inc;
                // A win ends the game even while invulnerable
                if (puntos_inc == META) begin
                  gano_d  = 1'b1;
                  state_d = FIN;
                end
              end
            end
          end
          default: ;
        endcase
      end
      WL, PA: ;
      default: ;
    endcase
  end

  assign bus.choque       = choque_q;
  assign bus.vidas        = vidas_q;
  assign bus.puntos       = puntos_q;
  assign bus.invulnerable = (state_q == INVULN);
  assign bus.gano         = gano_q;
  assign bus.perdio       = perdio_q;

endmodule

// File: tb/tb_detector_colision.sv
// tb/tb_detector_colision.sv - self-checking bench for detector_colision
module tb_detector_colision;

  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] CH   = 3'd2;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  typedef struct {
    logic [2:0] presente;
    logic [6:0] obs;
    logic [6:0] heroe;
    logic [7:0] puntos;
    logic [1:0] vidas;
    logic       inv;
    logic       gano;
    logic       perdio;
    int         choques;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ch_total;
  vec_t tbl[$];
  vec_t sb[$];

  detector_colision_if bus();

  detector_colision dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ch_total = 0;
  always @(negedge clk) if (bus.choque === 1'b1) ch_total = ch_total + 1;

  function automatic logic [7:0] bcd(input int i);
    return 8'(((i / 10) * 16) + (i % 10));
  endfunction

  function automatic logic [12:0] outs();
    return {bus.puntos, bus.vidas, bus.invulnerable, bus.gano, bus.perdio};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] p, input logic [6:0] o, input logic [6:0] h,
                     input logic [7:0] pts, input logic [1:0] v, input logic inv,
                     input logic g, input logic l, input int c);
    vec_t e;
    e.presente = p; e.obs = o; e.heroe = h; e.puntos = pts; e.vidas = v;
    e.inv = inv; e.gano = g; e.perdio = l; e.choques = c;
    tbl.push_back(e);
  endtask

  // One full clk_obstaculos period with the vector's inputs held steady
  task automatic apply(input int idx);
    vec_t v, e;
    int   c0;
    v = tbl[idx];
    bus.presente    = v.presente;
    bus.display_obs = v.obs;
    bus.heroe       = v.heroe;
    repeat (2) @(negedge clk);
    c0 = ch_total;
    sb.push_back(v);
    bus.clk_obstaculos = 1'b1;
    repeat (6) @(negedge clk);
    bus.clk_obstaculos = 1'b0;
    repeat (6) @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("vec%0d_outs", idx), 32'(outs()),
        32'({e.puntos, e.vidas, e.inv, e.gano, e.perdio}));
    chk($sformatf("vec%0d_choque", idx), 32'(ch_total - c0), 32'(e.choques));
  endtask

  initial begin
    int n1;
    checks = 0;
    errors = 0;

    // Part 1: scoring to META, freeze, invulnerability, pause, losing, restart
    for (int i = 0; i < 20; i++) add(GAME, 7'h08, 7'h01, bcd(i + 1), 2'd3, 1'b0, i == 19, 1'b0, 0);
    add(GAME, 7'h08, 7'h01, 8'h20, 2'd3, 1'b0, 1'b1, 1'b0, 0);
    add(OFF,  7'h08, 7'h01, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h08, 7'h08, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 1);
    add(GAME, 7'h08, 7'h08, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 0);
    add(GAME, 7'h08, 7'h08, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h00, 7'h08, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h08, 7'h01, 8'h01, 2'd2, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h01, 7'h01, 8'h01, 2'd1, 1'b1, 1'b0, 1'b0, 1);
    add(GAME, 7'h02, 7'h01, 8'h02, 2'd1, 1'b1, 1'b0, 1'b0, 0);
    add(GAME, 7'h04, 7'h01, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0, 0);
    add(PA,   7'h01, 7'h01, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0, 0);
    add(WL,   7'h04, 7'h01, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h7F, 7'h7F, 8'h03, 2'd0, 1'b0, 1'b0, 1'b1, 1);
    add(GAME, 7'h08, 7'h01, 8'h03, 2'd0, 1'b0, 1'b0, 1'b1, 0);
    add(CH,   7'h08, 7'h01, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) add(GAME, 7'h08, 7'h01, bcd(i + 1), 2'd3, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) add(PA, 7'h08, 7'h01, 8'h05, 2'd3, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h08, 7'h01, 8'h06, 2'd3, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h08, 7'h01, 8'h07, 2'd3, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h08, 7'h08, 8'h07, 2'd2, 1'b1, 1'b0, 1'b0, 1);
    n1 = tbl.size();
    // Part 2: 3 -> 0 lives with gaps covering invulnerability, then frozen
    add(GAME, 7'h08, 7'h08, 8'h01, 2'd2, 1'b1, 1'b0, 1'b0, 1);
    add(GAME, 7'h00, 7'h00, 8'h01, 2'd2, 1'b1, 1'b0, 1'b0, 0);
    add(GAME, 7'h00, 7'h00, 8'h01, 2'd2, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h10, 7'h10, 8'h01, 2'd1, 1'b1, 1'b0, 1'b0, 1);
    add(GAME, 7'h00, 7'h00, 8'h01, 2'd1, 1'b1, 1'b0, 1'b0, 0);
    add(GAME, 7'h00, 7'h00, 8'h01, 2'd1, 1'b0, 1'b0, 1'b0, 0);
    add(GAME, 7'h40, 7'h7F, 8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 1);
    add(GAME, 7'h08, 7'h01, 8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 0);

    rst = 1'b1;
    bus.presente       = OFF;
    bus.clk_obstaculos = 1'b0;
    bus.display_obs    = 7'h00;
    bus.heroe          = 7'h00;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({outs(), bus.choque}), 32'({8'h00, 2'd3, 3'b000, 1'b0}));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < n1; i++) apply(i);

    // Asynchronous reset while invulnerable with puntos=07
    chk("pre_rst_inv", 32'({bus.invulnerable, bus.puntos}), 32'({1'b1, 8'h07}));
    #2 rst = 1'b1;
    #1 chk("async_rst", 32'({outs(), bus.choque}), 32'({8'h00, 2'd3, 3'b000, 1'b0}));
    @(negedge clk);
    rst = 1'b0;

    // Exact 4-clk latency, then a level held high for 100 cycles scores once
    bus.presente    = GAME;
    bus.display_obs = 7'h08;
    bus.heroe       = 7'h01;
    repeat (2) @(negedge clk);
    bus.clk_obstaculos = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("latency_3clk", 32'(bus.puntos), 32'h00);
    @(negedge clk);
    chk("latency_4clk", 32'(bus.puntos), 32'h01);
    repeat (96) @(negedge clk);
    chk("hold_high", 32'(bus.puntos), 32'h01);
    bus.clk_obstaculos = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_released", 32'(outs()), 32'({8'h01, 2'd3, 3'b000}));

    for (int i = n1; i < tbl.size(); i++) apply(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
